// File: rtl/axi_stream2lite_interface_if.sv
// AXI-Lite slave and AXI-Stream slave signal bundle for the stream-to-lite return-path adapter.
interface axi_stream2lite_interface_if #(
    parameter int unsigned C_S00_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_S00_AXI_ADDR_WIDTH   = 5,
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32
);
    logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr;
    logic [2:0]                          s00_axi_awprot;
    logic                                s00_axi_awvalid;
    logic                                s00_axi_awready;
    logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata;
    logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb;
    logic                                s00_axi_wvalid;
    logic                                s00_axi_wready;
    logic [1:0]                          s00_axi_bresp;
    logic                                s00_axi_bvalid;
    logic                                s00_axi_bready;
    logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr;
    logic [2:0]                          s00_axi_arprot;
    logic                                s00_axi_arvalid;
    logic                                s00_axi_arready;
    logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata;
    logic [1:0]                          s00_axi_rresp;
    logic                                s00_axi_rvalid;
    logic                                s00_axi_rready;
    logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata;
    logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb;
    logic                                s00_axis_tlast;
    logic                                s00_axis_tvalid;
    logic                                s00_axis_tready;

    modport slave (
        input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid, s00_axi_bready,
        input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid, s00_axi_rready,
        input  s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, s00_axis_tvalid,
        output s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
        output s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        output s00_axis_tready
    );

    modport master (
        output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
        output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid, s00_axi_bready,
        output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid, s00_axi_rready,
        output s00_axis_tdata, s00_axis_tstrb, s00_axis_tlast, s00_axis_tvalid,
        input  s00_axi_awready, s00_axi_wready, s00_axi_bresp, s00_axi_bvalid,
        input  s00_axi_arready, s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
        input  s00_axis_tready
    );
endinterface

// File: rtl/axi_stream2lite_interface.sv
// Captures one stream packet (up to 4 beats) into a buffer held until software releases it over AXI-Lite.
// Optional feature macro: S2L_PKT_COUNT_EN adds a read-only packet counter at 0x18.
module axi_stream2lite_interface #(
    parameter int unsigned C_S00_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_S00_AXI_ADDR_WIDTH   = 5,
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                         s00_axi_aclk,
    input  logic                         s00_axi_aresetn,
    axi_stream2lite_interface_if.slave   bus,
    output logic                         pkt_ready
);
    localparam int unsigned DW       = C_S00_AXI_DATA_WIDTH;
    localparam int unsigned ADDR_LSB = 2;
    localparam int unsigned SW       = DW / 8;

    typedef enum logic [1:0] {RECV = 2'd0, DROP = 2'd1, FULL = 2'd2} state_t;

    state_t        state;
    logic [DW-1:0] data [4];
    logic [2:0]    cnt;
    logic          trunc;
    logic [DW-1:0] rd_mux;
    logic          beat;
    logic          wr_hs;
    logic          release_wr;
    logic [2:0]    wr_idx;
    logic [2:0]    rd_idx;

    assign wr_idx     = bus.s00_axi_awaddr[ADDR_LSB +: 3];
    assign rd_idx     = bus.s00_axi_araddr[ADDR_LSB +: 3];
    assign beat       = bus.s00_axis_tvalid & bus.s00_axis_tready;
    assign wr_hs      = bus.s00_axi_awready & bus.s00_axi_awvalid & bus.s00_axi_wready & bus.s00_axi_wvalid;
    assign release_wr = wr_hs && (wr_idx == 3'd5) && bus.s00_axi_wstrb[0] && bus.s00_axi_wdata[0];

    assign bus.s00_axi_bresp = 2'b00;
    assign bus.s00_axi_rresp = 2'b00;

    // Packet capture FSM; tready/pkt_ready are registered copies of the next state.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state               <= RECV;
            bus.s00_axis_tready <= 1'b0;
            pkt_ready           <= 1'b0;
            cnt                 <= 3'd0;
            trunc               <= 1'b0;
            for (int i = 0; i < 4; i++) data[i] <= '0;
        end else begin
            case (state)
                RECV: begin
                    bus.s00_axis_tready <= 1'b1;
                    pkt_ready           <= 1'b0;
                    if (beat) begin
                        data[cnt[1:0]] <= bus.s00_axis_tdata;
                        cnt            <= cnt + 3'd1;
                        if (bus.s00_axis_tlast) begin
                            state               <= FULL;
                            bus.s00_axis_tready <= 1'b0;
                            pkt_ready           <= 1'b1;
                        end else if (cnt == 3'd3) begin
                            state <= DROP;
                        end
                    end
                end
                DROP: begin
                    bus.s00_axis_tready <= 1'b1;
                    pkt_ready           <= 1'b0;
                    if (beat) begin
                        trunc <= 1'b1;
                        if (bus.s00_axis_tlast) begin
                            state               <= FULL;
                            bus.s00_axis_tready <= 1'b0;
                            pkt_ready           <= 1'b1;
                        end
                    end
                end
                FULL: begin
                    bus.s00_axis_tready <= 1'b0;
                    pkt_ready           <= 1'b1;
                    if (release_wr) begin
                        state               <= RECV;
                        bus.s00_axis_tready <= 1'b1;
                        pkt_ready           <= 1'b0;
                        cnt                 <= 3'd0;
                        trunc               <= 1'b0;
                    end
                end
                default: begin
                    state               <= RECV;
                    bus.s00_axis_tready <= 1'b0;
                    pkt_ready           <= 1'b0;
                end
            endcase
        end
    end

`ifdef S2L_PKT_COUNT_EN
    logic [DW-1:0] pkt_cnt;

    // Counts completed packets (entries into FULL), wrapping naturally.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            pkt_cnt <= '0;
        end else if (beat && bus.s00_axis_tlast && (state != FULL)) begin
            pkt_cnt <= pkt_cnt + DW'(1);
        end
    end
`endif

    // Write channel: address and data accepted together, single-cycle ready pulse.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            bus.s00_axi_awready <= 1'b0;
            bus.s00_axi_wready  <= 1'b0;
            bus.s00_axi_bvalid  <= 1'b0;
        end else begin
            bus.s00_axi_awready <= 1'b0;
            bus.s00_axi_wready  <= 1'b0;
            if (bus.s00_axi_awvalid && bus.s00_axi_wvalid && !bus.s00_axi_awready && !bus.s00_axi_bvalid) begin
                bus.s00_axi_awready <= 1'b1;
                bus.s00_axi_wready  <= 1'b1;
            end
            if (wr_hs) begin
                bus.s00_axi_bvalid <= 1'b1;
            end else if (bus.s00_axi_bready) begin
                bus.s00_axi_bvalid <= 1'b0;
            end
        end
    end

    // Read data mux, sampled on the arready pulse.
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            3'd0, 3'd1, 3'd2, 3'd3: rd_mux = data[rd_idx[1:0]];
            3'd4:    rd_mux = DW'({trunc, cnt, (state == FULL)});
`ifdef S2L_PKT_COUNT_EN
            3'd6:    rd_mux = pkt_cnt;
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            bus.s00_axi_arready <= 1'b0;
            bus.s00_axi_rvalid  <= 1'b0;
            bus.s00_axi_rdata   <= '0;
        end else begin
            bus.s00_axi_arready <= bus.s00_axi_arvalid && !bus.s00_axi_rvalid && !bus.s00_axi_arready;
            if (bus.s00_axi_arready && bus.s00_axi_arvalid) begin
                bus.s00_axi_rvalid <= 1'b1;
                bus.s00_axi_rdata  <= rd_mux;
            end else if (bus.s00_axi_rready) begin
                bus.s00_axi_rvalid <= 1'b0;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.s00_axi_awprot, bus.s00_axi_arprot, bus.s00_axis_tstrb,
                           bus.s00_axi_awaddr, bus.s00_axi_araddr,
                           bus.s00_axi_wstrb[SW-1:1], bus.s00_axi_wdata[DW-1:1]};
endmodule

// File: tb/tb_axi_stream2lite_interface.sv
// Self-checking bench for axi_stream2lite_interface: packet table plus hand-written corner sequences.
module tb_axi_stream2lite_interface;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pkt_ready;

    always #5 clk = ~clk;

    axi_stream2lite_interface_if bus();

    axi_stream2lite_interface dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .bus             (bus.slave),
        .pkt_ready       (pkt_ready)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int               nbeats;
        logic [5:0][31:0] beats;
        logic [31:0]      exp_status;
        logic [3:0][31:0] exp_data;
    } pkt_vec_t;
    pkt_vec_t vec[3];

`ifdef S2L_PKT_COUNT_EN
    localparam logic [31:0] EXP_PKTCNT_3 = 32'd3;
    localparam logic [31:0] EXP_PKTCNT_1 = 32'd1;
`else
    localparam logic [31:0] EXP_PKTCNT_3 = 32'd0;
    localparam logic [31:0] EXP_PKTCNT_1 = 32'd0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    task automatic axil_write(input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] strb);
        int n;
        @(negedge clk);
        bus.s00_axi_awaddr  = addr;
        bus.s00_axi_wdata   = wd;
        bus.s00_axi_wstrb   = strb;
        bus.s00_axi_awvalid = 1'b1;
        bus.s00_axi_wvalid  = 1'b1;
        n = 0;
        while (!(bus.s00_axi_awready && bus.s00_axi_wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            timeout_fail("aw_w_handshake");
            bus.s00_axi_awvalid = 1'b0;
            bus.s00_axi_wvalid  = 1'b0;
            return;
        end
        @(negedge clk);
        bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wvalid  = 1'b0;
        n = 0;
        while (!bus.s00_axi_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            timeout_fail("bvalid");
            return;
        end
        chk("bresp", 32'(bus.s00_axi_bresp), 32'd0);
        bus.s00_axi_bready = 1'b1;
        @(negedge clk);
        bus.s00_axi_bready = 1'b0;
    endtask

    task automatic axil_read(input logic [4:0] addr, output logic [31:0] rd);
        int n;
        rd = 32'hxxxx_xxxx;
        @(negedge clk);
        bus.s00_axi_araddr  = addr;
        bus.s00_axi_arvalid = 1'b1;
        n = 0;
        while (!bus.s00_axi_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            timeout_fail("arready");
            bus.s00_axi_arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        bus.s00_axi_arvalid = 1'b0;
        n = 0;
        while (!bus.s00_axi_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            timeout_fail("rvalid");
            return;
        end
        rd = bus.s00_axi_rdata;
        bus.s00_axi_rready = 1'b1;
        @(negedge clk);
        bus.s00_axi_rready = 1'b0;
    endtask

    // Expected value is queued when the read is issued and popped when the DUT returns data.
    task automatic check_read(input logic [4:0] addr, input logic [31:0] exp, input string name);
        sb_t         e;
        logic [31:0] d;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        axil_read(addr, d);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.name, d, e.exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat transferred.
    task automatic send_beat(input logic [31:0] d, input logic last, output int stalls);
        bus.s00_axis_tdata  = d;
        bus.s00_axis_tlast  = last;
        bus.s00_axis_tvalid = 1'b1;
        stalls = 0;
        while (!bus.s00_axis_tready && stalls < 20) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 20) timeout_fail("tready");
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stalls;
        int          total;
        logic [31:0] d;

        vec[0].nbeats = 4;
        vec[0].beats  = '0;
        vec[0].beats[0] = 32'h11; vec[0].beats[1] = 32'h22;
        vec[0].beats[2] = 32'h33; vec[0].beats[3] = 32'h44;
        vec[0].exp_status = 32'h09;
        vec[0].exp_data[0] = 32'h11; vec[0].exp_data[1] = 32'h22;
        vec[0].exp_data[2] = 32'h33; vec[0].exp_data[3] = 32'h44;

        vec[1].nbeats = 2;
        vec[1].beats  = '0;
        vec[1].beats[0] = 32'hA; vec[1].beats[1] = 32'hB;
        vec[1].exp_status = 32'h05;
        vec[1].exp_data[0] = 32'hA;  vec[1].exp_data[1] = 32'hB;
        vec[1].exp_data[2] = 32'h33; vec[1].exp_data[3] = 32'h44;

        vec[2].nbeats = 6;
        for (int i = 0; i < 6; i++) vec[2].beats[i] = 32'(i + 1);
        vec[2].exp_status = 32'h19;
        for (int i = 0; i < 4; i++) vec[2].exp_data[i] = 32'(i + 1);

        bus.s00_axi_awaddr = '0; bus.s00_axi_awprot = '0; bus.s00_axi_awvalid = 1'b0;
        bus.s00_axi_wdata  = '0; bus.s00_axi_wstrb  = '0; bus.s00_axi_wvalid  = 1'b0;
        bus.s00_axi_bready = 1'b0;
        bus.s00_axi_araddr = '0; bus.s00_axi_arprot = '0; bus.s00_axi_arvalid = 1'b0;
        bus.s00_axi_rready = 1'b0;
        bus.s00_axis_tdata = '0; bus.s00_axis_tstrb = '1; bus.s00_axis_tlast = 1'b0;
        bus.s00_axis_tvalid = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_tready", 32'(bus.s00_axis_tready), 32'd0);
        chk("reset_pkt_ready", 32'(pkt_ready), 32'd0);
        chk("reset_bvalid", 32'(bus.s00_axi_bvalid), 32'd0);
        chk("reset_rvalid", 32'(bus.s00_axi_rvalid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("tready_after_reset", 32'(bus.s00_axis_tready), 32'd1);
        check_read(5'h10, 32'h0, "status_idle");

        // Table-driven packets, each followed by readback and release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total = 0;
            for (int b = 0; b < vec[i].nbeats; b++) begin
                send_beat(vec[i].beats[b], (b == vec[i].nbeats - 1), stalls);
                total += stalls;
            end
            bus.s00_axis_tvalid = 1'b0;
            bus.s00_axis_tlast  = 1'b0;
            chk($sformatf("pkt%0d_stalls", i), 32'(total), 32'd0);
            chk($sformatf("pkt%0d_pkt_ready", i), 32'(pkt_ready), 32'd1);
            chk($sformatf("pkt%0d_tready_full", i), 32'(bus.s00_axis_tready), 32'd0);
            check_read(5'h10, vec[i].exp_status, $sformatf("pkt%0d_status", i));
            for (int j = 0; j < 4; j++)
                check_read(5'(j * 4), vec[i].exp_data[j], $sformatf("pkt%0d_data%0d", i, j));
            chk($sformatf("pkt%0d_tready_held", i), 32'(bus.s00_axis_tready), 32'd0);
            axil_write(5'h14, 32'h1, 4'hF);
            chk($sformatf("pkt%0d_tready_release", i), 32'(bus.s00_axis_tready), 32'd1);
            chk($sformatf("pkt%0d_pkt_ready_release", i), 32'(pkt_ready), 32'd0);
            check_read(5'h10, 32'h0, $sformatf("pkt%0d_status_release", i));
        end

        check_read(5'h18, EXP_PKTCNT_3, "pktcnt_after_3");
        check_read(5'h1C, 32'h0, "reserved_read");
        check_read(5'h14, 32'h0, "ctrl_read");
        axil_write(5'h00, 32'hDEAD_BEEF, 4'hF);
        check_read(5'h00, 32'h1, "data0_ro_write");

        // Release mid-packet is ignored.
        @(negedge clk);
        send_beat(32'h100, 1'b0, stalls);
        bus.s00_axis_tvalid = 1'b0;
        axil_write(5'h14, 32'h1, 4'hF);
        @(negedge clk);
        send_beat(32'h200, 1'b0, stalls);
        send_beat(32'h300, 1'b1, stalls);
        bus.s00_axis_tvalid = 1'b0;
        bus.s00_axis_tlast  = 1'b0;
        check_read(5'h10, 32'h07, "midrelease_status");
        check_read(5'h08, 32'h300, "midrelease_data2");
        check_read(5'h0C, 32'h4, "midrelease_data3_stale");

        // Release with wstrb[0]=0 or wdata[0]=0 leaves the buffer held.
        axil_write(5'h14, 32'h1, 4'h0);
        chk("nostrb_pkt_ready", 32'(pkt_ready), 32'd1);
        axil_write(5'h14, 32'h2, 4'hF);
        check_read(5'h10, 32'h07, "nobit0_status");

        // Beat pending while release lands: taken only once FSM is back in RECV.
        @(negedge clk);
        bus.s00_axis_tdata  = 32'h777;
        bus.s00_axis_tlast  = 1'b1;
        bus.s00_axis_tvalid = 1'b1;
        chk("pending_beat_tready", 32'(bus.s00_axis_tready), 32'd0);
        axil_write(5'h14, 32'h1, 4'hF);
        bus.s00_axis_tvalid = 1'b0;
        bus.s00_axis_tlast  = 1'b0;
        check_read(5'h10, 32'h03, "pending_beat_status");
        check_read(5'h00, 32'h777, "pending_beat_data0");
        check_read(5'h04, 32'h200, "pending_beat_data1_stale");
        axil_write(5'h14, 32'h1, 4'hF);

        // Reset mid-packet discards the partial capture.
        @(negedge clk);
        send_beat(32'hAA, 1'b0, stalls);
        send_beat(32'hBB, 1'b0, stalls);
        bus.s00_axis_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_tready", 32'(bus.s00_axis_tready), 32'd0);
        chk("midreset_pkt_ready", 32'(pkt_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midreset_tready_after", 32'(bus.s00_axis_tready), 32'd1);
        check_read(5'h10, 32'h0, "midreset_status");
        @(negedge clk);
        send_beat(32'h55, 1'b1, stalls);
        bus.s00_axis_tvalid = 1'b0;
        bus.s00_axis_tlast  = 1'b0;
        check_read(5'h10, 32'h03, "fresh_status");
        check_read(5'h00, 32'h55, "fresh_data0");
        check_read(5'h18, EXP_PKTCNT_1, "pktcnt_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
